// File: rtl/reduce_defs_pkg.sv
// Shared encodings for the sequential reduction block: operator select
// codes, FSM state codes and small helpers used by the datapath and flags.
package reduce_defs;

    // Operator select encodings
    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_XNOR = 2'b11;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Accumulator seed: AND starts from 1, every other operator from 0.
    function automatic logic mode_identity(input logic [1:0] m);
        return (m == MODE_AND);
    endfunction

    // XNOR is accumulated as XOR and only inverted when the result is written.
    function automatic logic mode_inverts(input logic [1:0] m);
        return (m == MODE_XNOR);
    endfunction

endpackage

// File: rtl/reduce_chunk.sv
// Combinational fold of one CHUNK-bit slice into the running accumulator.
module reduce_chunk
    import reduce_defs::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             acc,
    input  logic [1:0]       op,
    output logic             new_acc
);

    // Reduce the slice with the selected operator and merge it into acc
    always_comb begin
        // NOTE: a default assignment up front keeps every path driven, so no latch is inferred.
        new_acc = acc;
        case (op)
            MODE_AND:  new_acc = acc & (&chunk);
            MODE_OR:   new_acc = acc | (|chunk);
            MODE_XOR,
            MODE_XNOR: new_acc = acc ^ (^chunk);
            default:   new_acc = acc;
        endcase
    end

endmodule

// File: rtl/reduce_seq.sv
// Multi-cycle bitwise reduction: the operand is consumed CHUNK bits per
// cycle, LSB chunk first, and the single-bit result is registered on out.
module reduce_seq
    import reduce_defs::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic             out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(NCHUNK) + 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] sh;
    logic             acc;
    logic [1:0]       mode_q;
    logic [CW-1:0]    cnt;
    logic             out_q;
    logic             fold;
    logic             accept;
    logic             last_chunk;

    // A start is honoured only when no reduction is in flight.
    assign accept     = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign last_chunk = (state == ST_BUSY) && (cnt == LAST);

    reduce_chunk #(.CHUNK(CHUNK)) u_chunk (
        .chunk   (sh[CHUNK-1:0]),
        .acc     (acc),
        .op      (mode_q),
        .new_acc (fold)
    );

    // Next-state decode for the IDLE/BUSY/DONE controller
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_BUSY;
            ST_BUSY: if (cnt == LAST) next_state = ST_DONE;
            ST_DONE: next_state = start ? ST_BUSY : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State, operand shifter, accumulator, chunk counter and result register
    always_ff @(posedge clk) begin
        // NOTE: every register here is cleared by the synchronous reset; non-blocking updates keep the edge race-free.
        if (rst) begin
            state  <= ST_IDLE;
            sh     <= '0;
            acc    <= 1'b0;
            mode_q <= MODE_AND;
            cnt    <= '0;
            out_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                sh     <= in;
                mode_q <= mode;
                acc    <= mode_identity(mode);
                cnt    <= '0;
            end else if (state == ST_BUSY) begin
                acc <= fold;
                sh  <= sh >> CHUNK;
                if (last_chunk) begin
                    cnt   <= '0;
                    out_q <= mode_inverts(mode_q) ? ~fold : fold;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);
    assign out  = out_q;

endmodule

// File: doc/reduce_seq.md
REDUCE_SEQ -- requirements
Module: reduce_seq

Interface
REQ-001 Parameter WIDTH, default 16, is the operand width in bits; it SHALL be a multiple of CHUNK and at least 2.
REQ-002 Parameter CHUNK, default 4, is the bits reduced per cycle; it SHALL be a power of two with 1 <= CHUNK <= WIDTH.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: the reset; it SHALL be synchronous and active-high.
REQ-005 Port start, input, 1 bit: request to begin a reduction.
REQ-006 Port mode, input, 2 bits: reduction operator select. 00 AND, 01 OR, 10 XOR, 11 XNOR.
REQ-007 Port in, input, WIDTH bits: the operand vector.
REQ-008 Port busy, output, 1 bit: high while a reduction is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse indicating that out holds a new result.
REQ-010 Port out, output, 1 bit: the registered reduction result.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-012 Transitions SHALL be as follows.
- IDLE -> BUSY when start=1.
- BUSY -> DONE after NCHUNK = WIDTH/CHUNK BUSY cycles.
- DONE -> BUSY when start=1.
- DONE -> IDLE when start=0.
REQ-013 On an accepted start, the block SHALL latch in into an internal shift register and latch mode.
REQ-014 On an accepted start, the accumulator SHALL be loaded with the identity for the latched mode: 1 for AND, 0 for OR, XOR and XNOR.
REQ-015 Each BUSY cycle SHALL fold the low CHUNK bits of the shift register into the accumulator using the latched operator, then shift the register right by CHUNK.
REQ-016 The chunk-processing order SHALL be LSB chunk first.
REQ-017 XNOR mode SHALL compute XOR across all bits and invert the result only when writing out.
REQ-018 The chunk counter SHALL be clog2(NCHUNK)+1 bits wide and SHALL count 0..NCHUNK-1 without wrap-around ambiguity.
REQ-019 Latency SHALL be exact.
- start is sampled high in cycle 0.
- busy is high in cycles 1..NCHUNK.
- done is high in cycle NCHUNK+1.
- out is updated at the same edge that raises done.
REQ-020 out SHALL hold its value until the next DONE-entering edge or reset.
REQ-021 done SHALL be high in DONE only.
REQ-022 busy SHALL be high in BUSY only.
REQ-023 start while BUSY SHALL be ignored: no restart and no queuing.
REQ-024 Changes on in or mode during BUSY SHALL NOT affect the result.
REQ-025 start asserted in the DONE cycle SHALL be accepted (back-to-back operation): BUSY follows in the next cycle, and there is no IDLE bubble.
REQ-026 When CHUNK == WIDTH, there SHALL be a single BUSY cycle and done SHALL occur in cycle 2.
REQ-027 When CHUNK == 1, there SHALL be WIDTH BUSY cycles.

Reset
REQ-028 With rst=1 at a rising edge, the following SHALL hold on the next cycle regardless of state:
- state = IDLE;
- busy = 0, done = 0, out = 0;
- accumulator, shift register and counter = 0.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 A reset mid-BUSY SHALL discard the operation and SHALL produce no done pulse.

Structure
REQ-031 The mode encodings (AND, OR, XOR, XNOR) and the state encodings SHALL live in a shared package or include file, reduce_defs, so that the ALU and the flag logic can reuse them.
REQ-032 The combinational CHUNK-bit reduce-and-fold step SHALL be a sub-module, reduce_chunk (inputs: chunk, acc, op; output: new acc).
REQ-033 The FSM, counter, shift register and output register SHALL reside in reduce_seq.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-034 AND, in=16'hFFFF, start at cycle 0 -> busy in cycles 1-4, done only in cycle 5, out=1; in=16'hFF7F -> out=0.
REQ-035 OR, in=16'h0000 -> out=0; in=16'h0100 -> out=1; XOR in=16'h8003 -> out=1; XNOR in=16'h0007 -> out=0.
REQ-036 start held high through the DONE cycle with a new in=16'h0001 in OR mode -> busy in cycles 6-9, second done in cycle 10, out=1.
REQ-037 in changed from 16'hFFFF to 16'h0000 and start re-pulsed during cycle 2 of an AND operation -> result unaffected (out=1, done in cycle 5).
REQ-038 rst asserted in cycle 2 of an operation -> cycle 3 shows busy=0, done=0, out=0, and no done pulse follows.
REQ-039 Instance with CHUNK=16, XOR, in=16'h0001 -> busy in cycle 1 only, done in cycle 2, out=1.
